// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: CSR address map and
// the HPM snapshot reader state encoding.
package riscv_pkg;

    localparam logic [11:0] CSR_MHPM_COUNTER_3 = 12'hB03;

    typedef enum logic [2:0] {
        HPM_IDLE,
        HPM_FREEZE,
        HPM_READ,
        HPM_SEND,
        HPM_DONE
    } hpm_snap_state_e;

endpackage

// File: rtl/hpm_snapshot_reader.sv
// HPM snapshot reader: freezes the hardware perf counters,
// reads (optionally clears) each one and streams it out.
module hpm_snapshot_reader
    import riscv_pkg::*;
#(
    parameter int CSR_ADDR_WIDTH   = 12,
    parameter int XLEN             = 64,
    parameter int HPM_NUM_COUNTERS = 29
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      start_i,
    input  logic                      clear_on_read_i,
    input  logic                      auto_trig_en_i,
    input  logic                      count_ovf_int_req_i,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
    output logic                      csr_we_o,
    output logic [XLEN-1:0]           csr_wdata_o,
    input  logic [XLEN-1:0]           csr_rdata_i,
    output logic                      freeze_o,
    output logic                      snap_valid_o,
    input  logic                      snap_ready_i,
    output logic [4:0]                snap_idx_o,
    output logic [XLEN-1:0]           snap_data_o,
    output logic                      snap_last_o,
    output logic                      busy_o,
    output logic                      done_o
);

    if (XLEN != 64) begin : g_bad_xlen
        $error("hpm_snapshot_reader: XLEN must be 64");
    end

    if (HPM_NUM_COUNTERS < 1 || HPM_NUM_COUNTERS > 29) begin : g_bad_num
        $error("hpm_snapshot_reader: HPM_NUM_COUNTERS out of 1..29");
    end

    localparam logic [4:0] IDX_FIRST = 5'd3;
    localparam logic [4:0] IDX_LAST  = 5'(HPM_NUM_COUNTERS + 2);

    hpm_snap_state_e state_q, state_d;
    logic [4:0]      idx_q, idx_d;
    logic            clr_q, clr_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [4:0]      sidx_q, sidx_d;
    logic            last_q, last_d;

    logic ovf_req;
    logic trig;

    assign ovf_req = auto_trig_en_i & count_ovf_int_req_i;
    assign trig    = start_i | ovf_req | pend_q;

    // Next-state, CSR access and beat capture
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        clr_d       = clr_q;
        pend_d      = pend_q;
        data_d      = data_q;
        sidx_d      = sidx_q;
        last_d      = last_q;
        csr_addr_o  = '0;
        csr_we_o    = 1'b0;
        csr_wdata_o = '0;

        // An overflow seen mid-snapshot is remembered for one more run
        if (state_q != HPM_IDLE && ovf_req) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            HPM_IDLE: begin
                if (trig) begin
                    state_d = HPM_FREEZE;
                    clr_d   = clear_on_read_i;
                    idx_d   = IDX_FIRST;
                    pend_d  = 1'b0;
                end
            end
            HPM_FREEZE: begin
                state_d = HPM_READ;
            end
            HPM_READ: begin
                csr_addr_o = CSR_ADDR_WIDTH'(CSR_MHPM_COUNTER_3)
                           + CSR_ADDR_WIDTH'(idx_q - IDX_FIRST);
                csr_we_o   = clr_q;
                data_d     = csr_rdata_i;
                sidx_d     = idx_q;
                last_d     = (idx_q == IDX_LAST);
                state_d    = HPM_SEND;
            end
            HPM_SEND: begin
                if (snap_ready_i) begin
                    if (last_q) begin
                        state_d = HPM_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = HPM_READ;
                    end
                end
            end
            HPM_DONE: begin
                state_d = HPM_IDLE;
            end
            default: begin
                state_d = HPM_IDLE;
            end
        endcase
    end

    // State and beat registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= HPM_IDLE;
            idx_q   <= '0;
            clr_q   <= 1'b0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            sidx_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            clr_q   <= clr_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            sidx_q  <= sidx_d;
            last_q  <= last_d;
        end
    end

    assign freeze_o     = (state_q != HPM_IDLE);
    assign busy_o       = (state_q != HPM_IDLE);
    assign done_o       = (state_q == HPM_DONE);
    assign snap_valid_o = (state_q == HPM_SEND);
    assign snap_idx_o   = sidx_q;
    assign snap_data_o  = data_q;
    assign snap_last_o  = last_q;

endmodule

// File: tb/tb_hpm_snapshot_reader.sv
// Directed bench for hpm_snapshot_reader with a counter-block
// model and a beat-level scoreboard.
`timescale 1ns/1ps
module tb_hpm_snapshot_reader;

    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        start_i;
    logic        clear_on_read_i;
    logic        auto_trig_en_i;
    logic        count_ovf_int_req_i;
    logic [11:0] csr_addr_o;
    logic        csr_we_o;
    logic [63:0] csr_wdata_o;
    logic [63:0] csr_rdata_i;
    logic        freeze_o;
    logic        snap_valid_o;
    logic        snap_ready_i;
    logic [4:0]  snap_idx_o;
    logic [63:0] snap_data_o;
    logic        snap_last_o;
    logic        busy_o;
    logic        done_o;

    always #5 clk = ~clk;

    hpm_snapshot_reader #(
        .CSR_ADDR_WIDTH(12),
        .XLEN(64),
        .HPM_NUM_COUNTERS(29)
    ) dut (
        .clk_i(clk),
        .rstn_i(rstn_i),
        .start_i(start_i),
        .clear_on_read_i(clear_on_read_i),
        .auto_trig_en_i(auto_trig_en_i),
        .count_ovf_int_req_i(count_ovf_int_req_i),
        .csr_addr_o(csr_addr_o),
        .csr_we_o(csr_we_o),
        .csr_wdata_o(csr_wdata_o),
        .csr_rdata_i(csr_rdata_i),
        .freeze_o(freeze_o),
        .snap_valid_o(snap_valid_o),
        .snap_ready_i(snap_ready_i),
        .snap_idx_o(snap_idx_o),
        .snap_data_o(snap_data_o),
        .snap_last_o(snap_last_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    int checks = 0;
    int errors = 0;

    // counter block model
    logic [63:0] cnt [0:31];
    logic        events;
    logic        load_en;
    logic [63:0] load_c5;

    // scoreboard
    beat_t       exp_arr [0:511];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [63:0] last_snap [0:31];
    logic        cur_clear;
    int          we_cnt = 0;

    // ready driver control
    int hold_idx;
    int hold_len;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Counter block: read port decodes the mhpmcounter window
    always_comb begin
        csr_rdata_i = '0;
        if (csr_addr_o >= 12'hB03 && csr_addr_o <= 12'hB1F)
            csr_rdata_i = cnt[5'(csr_addr_o - 12'hB00)];
    end

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 32; i++)
                cnt[i] <= (i == 5) ? load_c5 : 64'h100 + 64'(i);
        end else if (csr_we_o && csr_addr_o >= 12'hB03
                     && csr_addr_o <= 12'hB1F) begin
            cnt[5'(csr_addr_o - 12'hB00)] <= csr_wdata_o;
        end else if (events && !freeze_o) begin
            for (int i = 3; i < 32; i++)
                cnt[i] <= cnt[i] + 64'd1;
        end
    end

    // Ready driver: stalls one chosen beat for hold_len cycles
    initial begin
        int  hold_cnt;
        bit  held;
        hold_cnt = 0;
        held = 0;
        snap_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!snap_valid_o && !busy_o) held = 0;
            if (hold_cnt > 0) begin
                hold_cnt--;
                snap_ready_i = 1'b0;
            end else if (snap_valid_o && int'(snap_idx_o) == hold_idx
                         && !held) begin
                snap_ready_i = 1'b0;
                held = 1;
                hold_cnt = hold_len - 1;
            end else begin
                snap_ready_i = 1'b1;
            end
        end
    end

    // Compare process: beats, stability, done pulse, CSR writes
    initial begin
        bit          exp_done;
        bit          nxt_done;
        bit          prev_valid;
        bit          prev_hs;
        logic [4:0]  p_idx;
        logic [63:0] p_data;
        logic        p_last;
        exp_done = 0;
        prev_valid = 0;
        prev_hs = 0;
        p_idx = '0;
        p_data = '0;
        p_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn_i) begin
                rd_ptr = wr_ptr;
                exp_done = 0;
                prev_valid = 0;
                prev_hs = 0;
            end else begin
                nxt_done = 0;
                chk("done_o", 64'(done_o), 64'(exp_done));
                if (csr_we_o) begin
                    we_cnt++;
                    chk("we_needs_clear", 64'(cur_clear), 64'd1);
                    chk("we_addr_range", 64'(csr_addr_o >= 12'hB03
                        && csr_addr_o <= 12'hB1F), 64'd1);
                    chk("we_wdata", csr_wdata_o, 64'd0);
                end
                if (snap_valid_o) begin
                    chk("valid_freeze", 64'(freeze_o), 64'd1);
                    if (prev_valid && !prev_hs) begin
                        chk("hold_idx", 64'(snap_idx_o), 64'(p_idx));
                        chk("hold_data", snap_data_o, p_data);
                        chk("hold_last", 64'(snap_last_o), 64'(p_last));
                    end
                    chk("beat_expected", 64'(rd_ptr < wr_ptr), 64'd1);
                    if (rd_ptr < wr_ptr) begin
                        chk("beat_idx", 64'(snap_idx_o),
                            64'(exp_arr[rd_ptr].idx));
                        chk("beat_data", snap_data_o,
                            exp_arr[rd_ptr].data);
                        chk("beat_last", 64'(snap_last_o),
                            64'(exp_arr[rd_ptr].last));
                        if (snap_ready_i) begin
                            nxt_done = exp_arr[rd_ptr].last;
                            rd_ptr++;
                        end
                    end
                end
                prev_valid = snap_valid_o;
                prev_hs = snap_valid_o && snap_ready_i;
                p_idx = snap_idx_o;
                p_data = snap_data_o;
                p_last = snap_last_o;
                exp_done = nxt_done;
            end
        end
    end

    task automatic load(input logic [63:0] c5);
        load_c5 = c5;
        load_en = 1'b1;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    // Frozen counter values become the expected beats
    task automatic push_snap();
        for (int i = 3; i <= 31; i++) begin
            exp_arr[wr_ptr] = '{idx: 5'(i), data: cnt[i], last: (i == 31)};
            last_snap[i] = cnt[i];
            wr_ptr++;
        end
    endtask

    task automatic trigger(input logic clr, input logic ovf);
        clear_on_read_i = clr;
        cur_clear = clr;
        start_i = 1'b1;
        count_ovf_int_req_i = ovf;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        count_ovf_int_req_i = 1'b0;
        push_snap();
    endtask

    task automatic run_to_done(output int first_v, output int done_c);
        first_v = -1;
        done_c = -1;
        for (int k = 0; k < 400; k++) begin
            if (snap_valid_o && first_v < 0) first_v = k + 1;
            if (done_o) begin
                done_c = k + 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("done_seen", 64'(done_c > 0), 64'd1);
    endtask

    task automatic wait_beat(input int idx);
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (snap_valid_o && int'(snap_idx_o) == idx) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("beat_reached", 64'(ok), 64'd1);
    endtask

    task automatic idle_for(input int n, output bit any_busy);
        any_busy = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (busy_o) any_busy = 1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, 64'(csr_addr_o), 64'd0);
        chk({tag, "_we"}, 64'(csr_we_o), 64'd0);
        chk({tag, "_wdata"}, csr_wdata_o, 64'd0);
        chk({tag, "_freeze"}, 64'(freeze_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_valid"}, 64'(snap_valid_o), 64'd0);
        chk({tag, "_last"}, 64'(snap_last_o), 64'd0);
        chk({tag, "_idx"}, 64'(snap_idx_o), 64'd0);
        chk({tag, "_data"}, snap_data_o, 64'd0);
    endtask

    initial begin
        int          fv;
        int          dc;
        int          we0;
        bit          bsy;
        logic [63:0] d7;

        rstn_i = 1'b0;
        start_i = 1'b0;
        clear_on_read_i = 1'b0;
        auto_trig_en_i = 1'b0;
        count_ovf_int_req_i = 1'b0;
        events = 1'b0;
        load_en = 1'b0;
        load_c5 = '0;
        cur_clear = 1'b0;
        hold_idx = -1;
        hold_len = 10;

        // reset state, even with a start request pending
        #1;
        chk_all_zero("rst");
        start_i = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_start_busy", 64'(busy_o), 64'd0);
        start_i = 1'b0;
        rstn_i = 1'b1;
        load(64'h105);

        // plain snapshot, no clear
        trigger(1'b0, 1'b0);
        run_to_done(fv, dc);
        chk("first_valid_cycle", 64'(fv), 64'd3);
        chk("done_cycle", 64'(dc), 64'd60);
        chk("snap_first_data", exp_arr[0].data, 64'h103);
        chk("snap_last_data", exp_arr[28].data, 64'h11F);
        chk("cnt3_kept", cnt[3], 64'h103);
        chk("cnt31_kept", cnt[31], 64'h11F);
        idle_for(3, bsy);

        // clear on read
        load(64'hFFFF);
        we0 = we_cnt;
        trigger(1'b1, 1'b0);
        wait_beat(5);
        chk("c5_beat_data", snap_data_o, 64'hFFFF);
        run_to_done(fv, dc);
        chk("we_cycles", 64'(we_cnt - we0), 64'd29);
        for (int i = 3; i <= 31; i++)
            chk("cleared", cnt[i], 64'd0);
        idle_for(3, bsy);

        // stalled beat with counters running; start while busy
        load(64'h105);
        events = 1'b1;
        idle_for(4, bsy);
        hold_idx = 7;
        hold_len = 10;
        trigger(1'b0, 1'b0);
        wait_beat(7);
        d7 = snap_data_o;
        chk("c7_frozen_data", d7, last_snap[7]);
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid", 64'(snap_valid_o), 64'd1);
            chk("stall_idx", 64'(snap_idx_o), 64'd7);
            chk("stall_data", snap_data_o, d7);
            chk("stall_freeze", 64'(freeze_o), 64'd1);
            if (k == 4) start_i = 1'b1;
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        run_to_done(fv, dc);
        chk("frozen_cnt3", cnt[3], last_snap[3]);
        chk("frozen_cnt31", cnt[31], last_snap[31]);
        hold_idx = -1;
        events = 1'b0;
        idle_for(5, bsy);
        chk("start_busy_ignored", 64'(bsy), 64'd0);

        // overflow requests during a snapshot merge into one rerun
        auto_trig_en_i = 1'b1;
        trigger(1'b0, 1'b0);
        idle_for(5, bsy);
        count_ovf_int_req_i = 1'b1;
        idle_for(1, bsy);
        count_ovf_int_req_i = 1'b0;
        idle_for(10, bsy);
        count_ovf_int_req_i = 1'b1;
        idle_for(1, bsy);
        count_ovf_int_req_i = 1'b0;
        run_to_done(fv, dc);
        @(posedge clk);
        #1;
        chk("gap_busy", 64'(busy_o), 64'd0);
        @(posedge clk);
        #1;
        push_snap();
        chk("rerun_busy", 64'(busy_o), 64'd1);
        run_to_done(fv, dc);
        chk("rerun_done_cycle", 64'(dc), 64'd60);
        idle_for(8, bsy);
        chk("merged_single", 64'(bsy), 64'd0);

        // start and overflow together: one snapshot, nothing pending
        trigger(1'b0, 1'b1);
        run_to_done(fv, dc);
        idle_for(8, bsy);
        chk("same_cycle_single", 64'(bsy), 64'd0);
        auto_trig_en_i = 1'b0;

        // reset while holding beat 12
        load(64'h105);
        hold_idx = 12;
        hold_len = 20;
        trigger(1'b1, 1'b0);
        wait_beat(12);
        @(posedge clk);
        #3;
        rstn_i = 1'b0;
        #1;
        chk_all_zero("abort");
        @(posedge clk);
        #1;
        chk("abort_freeze", 64'(freeze_o), 64'd0);
        rstn_i = 1'b1;
        we0 = we_cnt;
        hold_idx = -1;
        idle_for(25, bsy);
        chk("no_we_after_rst", 64'(we_cnt - we0), 64'd0);
        chk("idle_after_rst", 64'(bsy), 64'd0);
        trigger(1'b0, 1'b0);
        wait_beat(3);
        chk("restart_idx", 64'(snap_idx_o), 64'd3);
        run_to_done(fv, dc);
        idle_for(3, bsy);

        chk("beats_consumed", 64'(rd_ptr), 64'(wr_ptr));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hpm_snapshot_reader.md
HPM_SNAPSHOT_READER -- requirements
Module: hpm_snapshot_reader

Interface
REQ-001 SHALL have parameter CSR_ADDR_WIDTH, default 12, CSR address width.
REQ-002 SHALL have parameter XLEN, default 64, CSR data width; any other value is an elaboration error.
REQ-003 SHALL have parameter HPM_NUM_COUNTERS, default 29, number of counters read, indices 3..HPM_NUM_COUNTERS+2.
REQ-004 SHALL have ports, in this order:
- clk_i  in  1  clock; one clock domain.
- rstn_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  request a snapshot.
- clear_on_read_i  in  1  zero each counter as it is read; sampled on the accepted trigger.
- auto_trig_en_i  in  1  let an overflow request trigger a snapshot.
- count_ovf_int_req_i  in  1  overflow request from the counter block.
- csr_addr_o  out  CSR_ADDR_WIDTH  CSR address to the counter block.
- csr_we_o  out  1  CSR write enable.
- csr_wdata_o  out  XLEN  CSR write data.
- csr_rdata_i  in  XLEN  CSR read data; combinational from csr_addr_o.
- freeze_o  out  1  counter freeze; ORed externally into mcountinhibit[31:3].
- snap_valid_o  out  1  snapshot beat valid.
- snap_ready_i  in  1  snapshot beat accepted.
- snap_idx_o  out  5  counter index of the beat.
- snap_data_o  out  XLEN  counter value of the beat.
- snap_last_o  out  1  final beat of the snapshot.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse at completion.

Function
REQ-005 SHALL implement a registered FSM with states IDLE, FREEZE, READ, SEND and DONE.
REQ-006 IDLE: a trigger is start_i, or auto_trig_en_i && count_ovf_int_req_i; a trigger SHALL move to FREEZE, latch clear_on_read_i and set idx=3.
REQ-007 FREEZE SHALL last exactly 1 cycle with freeze_o=1, then move to READ; this lets counters settle before the first read.
REQ-008 freeze_o SHALL be 1 in FREEZE, READ, SEND and DONE, and 0 in IDLE.
REQ-009 READ SHALL last 1 cycle and drive csr_addr_o = CSR_MHPM_COUNTER_3 + (idx-3); csr_addr_o SHALL be 0 outside READ.
- In the same cycle csr_we_o = latched clear and csr_wdata_o = 0.
- Read and clear of one counter are therefore atomic.
REQ-010 At the READ->SEND edge, csr_rdata_i SHALL be captured into snap_data_o, with snap_idx_o=idx and snap_last_o=(idx==HPM_NUM_COUNTERS+2).
REQ-011 SEND SHALL hold snap_valid_o=1 with idx, data and last stable until snap_ready_i=1.
- On handshake, if last, move to DONE.
- Otherwise increment idx and move to READ.
REQ-012 With snap_ready_i held at 1, each counter SHALL take 2 cycles, and the first snap_valid_o SHALL rise 3 cycles after the trigger cycle.
REQ-013 DONE SHALL pulse done_o for 1 cycle and then return to IDLE; freeze_o falls on entry to IDLE.
REQ-014 start_i while busy SHALL be ignored.
REQ-015 A qualified overflow request while busy SHALL set a one-deep pending flag.
- Further requests while the flag is set are merged into it.
- A set flag acts as a trigger in IDLE and is cleared when that trigger is accepted.
REQ-016 start_i and a qualified overflow request in the same IDLE cycle SHALL give one snapshot and SHALL NOT set the pending flag.
REQ-017 csr_we_o SHALL never be asserted outside READ, and never with clear=0.
REQ-018 idx SHALL be 5 bits and SHALL never exceed HPM_NUM_COUNTERS+2; there is no wrap-around.

Reset
REQ-019 While rstn_i=0:
- state=IDLE; pending, idx and clear flag = 0.
- All outputs 0: freeze_o, busy_o, done_o, snap_valid_o, snap_last_o, snap_idx_o, snap_data_o, csr_addr_o, csr_we_o, csr_wdata_o.
REQ-020 Reset during a snapshot SHALL abort it immediately and drop freeze_o; no partial write is issued after reset release.

Structure
REQ-021 The FSM state enum and CSR address constants (CSR_MHPM_COUNTER_3) SHALL come from riscv_pkg; no new package is required.
REQ-022 SHALL be one flat module with no sub-modules.

Verification
REQ-023 Start, clear=0, ready=1, counters preloaded with value 0x100+i:
- 29 beats, idx 3..31, data 0x103..0x11F.
- last only on idx 31; done_o at cycle 60; counters unchanged.
REQ-024 Start, clear=1, counter 5=0xFFFF:
- beat idx 5 carries 0xFFFF.
- After done, all counters read 0; csr_we_o asserted exactly 29 cycles.
REQ-025 ready low for 10 cycles on beat idx 7:
- snap_valid_o, idx 7 and data held stable for all 10 cycles; freeze_o stays 1.
- With events active, no counter changes value.
REQ-026 Overflow request with auto_trig_en=1 during a start-initiated snapshot:
- a second snapshot begins 1 cycle after done_o; a further overflow request merges into the same pending snapshot.
REQ-027 rstn_i low while in SEND at idx 12:
- all outputs 0 asynchronously, freeze_o=0, no CSR write after release.
- A new start then begins at idx 3.
